// File: rtl/mem_stage_pkg.sv
// Shared types, constants and lane helpers for the handshaked memory stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  localparam int unsigned CONTROL_NOP_W = 16;
  localparam logic [CONTROL_NOP_W-1:0] CONTROL_NOP = 16'h0013;

  // Byte enables for an 8-lane bus; narrower buses keep the low lanes.
  function automatic logic [7:0] be_gen(size_e size, logic [2:0] off);
    logic [7:0] be;
    case (size)
      SZ_B:    be = 8'h01 << off;
      SZ_H:    be = 8'h03 << off;
      SZ_W:    be = 8'h0F << off;
      default: be = 8'hFF;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(size_e size, logic [2:0] off);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      SZ_W:    mis = (off[1:0] != 2'b00);
      default: mis = (off != 3'b000);
    endcase
    return mis;
  endfunction

  // Round the lane offset down to the natural boundary of the access size.
  function automatic logic [2:0] align_off(size_e size, logic [2:0] off);
    logic [2:0] a;
    case (size)
      SZ_B:    a = off;
      SZ_H:    a = {off[2:1], 1'b0};
      SZ_W:    a = {off[2], 2'b00};
      default: a = 3'b000;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load lane shift, truncation and sign/zero extension.
module mem_load_align
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]                  size,
  input  logic                        zext,
  input  logic [$clog2(XLEN/8)-1:0]   off,
  input  logic [XLEN-1:0]             rdata,
  output logic [XLEN-1:0]             data_c
);

  logic [63:0] shifted;
  logic [63:0] ext;
  logic        sx;

  // Work on a 64-bit view so one body serves both datapath widths.
  always_comb begin
    shifted = 64'(rdata) >> {off, 3'b000};
    sx      = 1'b0;
    ext     = shifted;
    case (size_e'(size))
      SZ_B: begin
        sx  = !zext && shifted[7];
        ext = {{56{sx}}, shifted[7:0]};
      end
      SZ_H: begin
        sx  = !zext && shifted[15];
        ext = {{48{sx}}, shifted[15:0]};
      end
      SZ_W: begin
        sx  = !zext && shifted[31];
        ext = {{32{sx}}, shifted[31:0]};
      end
      default: ext = shifted;
    endcase
    data_c = XLEN'(ext);
  end

endmodule

// File: rtl/mem_stage_hs.sv
// Handshaked pipeline memory stage: execute -> dmem request/response -> writeback.
// Optional MEM_MISALIGN_TRAP_EN: misaligned ops skip memory and flag wb_misalign_o.
module mem_stage_hs
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned RD_W   = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                exec_valid_i,
  output logic                exec_ready_o,
  input  logic [CTRL_W-1:0]   exec_ctrl_i,
  input  logic                exec_mem_rd_i,
  input  logic                exec_mem_wr_i,
  input  logic [1:0]          exec_size_i,
  input  logic                exec_unsigned_i,
  input  logic [XLEN-1:0]     exec_alu_i,
  input  logic [XLEN-1:0]     exec_wdata_i,
  input  logic [RD_W-1:0]     exec_rd_i,
  input  logic [XLEN-1:0]     exec_pcplus_i,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic [CTRL_W-1:0]   wb_ctrl_o,
  output logic [XLEN-1:0]     wb_alu_o,
  output logic [XLEN-1:0]     wb_rdata_o,
  output logic [RD_W-1:0]     wb_rd_o,
  output logic [XLEN-1:0]     wb_pcplus_o,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                wb_misalign_o,
`endif
  output logic                dmem_req_valid_o,
  input  logic                dmem_req_ready_i,
  output logic                dmem_we_o,
  output logic [XLEN/8-1:0]   dmem_be_o,
  output logic [ADDR_W-1:0]   dmem_addr_o,
  output logic [XLEN-1:0]     dmem_wdata_o,
  input  logic                dmem_rsp_valid_i,
  input  logic [XLEN-1:0]     dmem_rdata_i
);

  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);

  state_e            state_q, state_d;
  size_e             size_in, sz_q;
  logic [OFF_W-1:0]  off_in, off_use, off_q;
  logic              zext_q;
  logic              accept, is_mem, issue, pass;
  logic              grant, st_done, ld_done;
  logic [XLEN-1:0]   wdata_rep, ld_data;

  assign size_in      = size_e'(exec_size_i);
  assign off_in       = exec_alu_i[OFF_W-1:0];
  assign is_mem       = exec_mem_rd_i || exec_mem_wr_i;
  assign exec_ready_o = (state_q == ST_IDLE) && (!wb_valid_o || wb_ready_i);
  assign accept       = exec_valid_i && exec_ready_o;

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_mem;
  assign mis_mem = is_mem && misaligned(size_in, 3'(off_in));
  assign off_use = off_in;
  assign issue   = accept && is_mem && !mis_mem;
  assign pass    = accept && (!is_mem || mis_mem);
`else
  assign off_use = OFF_W'(align_off(size_in, 3'(off_in)));
  assign issue   = accept && is_mem;
  assign pass    = accept && !is_mem;
`endif

  // Store data replicated across every lane of the access size.
  always_comb begin
    case (size_in)
      SZ_B:    wdata_rep = {BE_W{exec_wdata_i[7:0]}};
      SZ_H:    wdata_rep = {(XLEN/16){exec_wdata_i[15:0]}};
      SZ_W:    wdata_rep = {(XLEN/32){exec_wdata_i[31:0]}};
      default: wdata_rep = exec_wdata_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    st_done = 1'b0;
    ld_done = 1'b0;
    case (state_q)
      ST_IDLE: if (issue) state_d = ST_REQ;
      ST_REQ: begin
        if (dmem_req_ready_i) begin
          grant   = 1'b1;
          st_done = dmem_we_o;
          state_d = dmem_we_o ? ST_IDLE : ST_RSP;
        end
      end
      ST_RSP: begin
        if (dmem_rsp_valid_i) begin
          ld_done = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  mem_load_align #(.XLEN(XLEN)) u_align (
    .size   (sz_q),
    .zext   (zext_q),
    .off    (off_q),
    .rdata  (dmem_rdata_i),
    .data_c (ld_data)
  );

  // Request side: captured on accept, held stable until the grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dmem_req_valid_o <= 1'b0;
      dmem_we_o        <= 1'b0;
      dmem_be_o        <= '0;
      dmem_addr_o      <= '0;
      dmem_wdata_o     <= '0;
      sz_q             <= SZ_B;
      zext_q           <= 1'b0;
      off_q            <= '0;
    end else if (issue) begin
      dmem_req_valid_o <= 1'b1;
      dmem_we_o        <= exec_mem_wr_i;
      dmem_be_o        <= BE_W'(be_gen(size_in, 3'(off_use)));
      dmem_addr_o      <= ADDR_W'(exec_alu_i) & ~ADDR_W'(BE_W - 1);
      dmem_wdata_o     <= wdata_rep;
      sz_q             <= size_in;
      zext_q           <= exec_unsigned_i;
      off_q            <= off_use;
    end else if (grant) begin
      dmem_req_valid_o <= 1'b0;
    end
  end

  // Writeback side: memory ops park their payload here while wb_valid_o is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_o    <= 1'b0;
      wb_ctrl_o     <= CTRL_W'(CONTROL_NOP);
      wb_alu_o      <= '0;
      wb_rdata_o    <= '0;
      wb_rd_o       <= '0;
      wb_pcplus_o   <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      wb_misalign_o <= 1'b0;
`endif
    end else begin
      if (pass || st_done || ld_done) wb_valid_o <= 1'b1;
      else if (issue || wb_ready_i)   wb_valid_o <= 1'b0;
      if (pass || issue) begin
        wb_ctrl_o     <= exec_ctrl_i;
        wb_alu_o      <= exec_alu_i;
        wb_rdata_o    <= '0;
        wb_rd_o       <= exec_rd_i;
        wb_pcplus_o   <= exec_pcplus_i;
`ifdef MEM_MISALIGN_TRAP_EN
        wb_misalign_o <= pass && mis_mem;
`endif
      end
      if (ld_done) wb_rdata_o <= ld_data;
    end
  end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
- Next-generation pipeline memory stage between execute and writeback.
- Replaces the fixed single-cycle, always-ready data-memory path with three handshaked interfaces:
  - valid/ready on the execute side and the writeback side;
  - request/grant plus response on the data-memory side.
- Adds sub-word loads and stores (byte enables, lane alignment, sign/zero extension) and tolerates variable memory latency.

Parameters:
- XLEN, 32: datapath width; 32 or 64.
- ADDR_W, 32: data-memory address width.
- CTRL_W, 16: width of the opaque control word passed through to writeback.
- RD_W, 5: destination register index width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- exec_valid_i  in  1  execute payload valid
- exec_ready_o  out  1  stage can accept a payload
- exec_ctrl_i  in  CTRL_W  opaque control, passed through
- exec_mem_rd_i  in  1  load
- exec_mem_wr_i  in  1  store
- exec_size_i  in  2  access size: 0=B, 1=H, 2=W, 3=D (D only when XLEN=64)
- exec_unsigned_i  in  1  zero-extend load
- exec_alu_i  in  XLEN  ALU result; used as address for memory ops
- exec_wdata_i  in  XLEN  store data
- exec_rd_i  in  RD_W  destination register
- exec_pcplus_i  in  XLEN  PC+4
- wb_valid_o  out  1  writeback payload valid
- wb_ready_i  in  1  writeback accepts
- wb_ctrl_o  out  CTRL_W  registered control
- wb_alu_o  out  XLEN  registered ALU result
- wb_rdata_o  out  XLEN  aligned, extended load data
- wb_rd_o  out  RD_W  registered destination
- wb_pcplus_o  out  XLEN  registered PC+4
- dmem_req_valid_o  out  1  memory request
- dmem_req_ready_i  in  1  memory grant
- dmem_we_o  out  1  write enable
- dmem_be_o  out  XLEN/8  byte enables
- dmem_addr_o  out  ADDR_W  word-aligned address
- dmem_wdata_o  out  XLEN  lane-replicated store data
- dmem_rsp_valid_i  in  1  load data valid
- dmem_rdata_i  in  XLEN  load data

Behaviour:
- Reset (asynchronous, rst_ni low):
  - state=IDLE; wb_valid_o=0; dmem_req_valid_o=0.
  - wb_ctrl_o=CONTROL_NOP; all other wb_* outputs and dmem_* outputs =0.
- exec_ready_o = (state==IDLE) && (!wb_valid_o || wb_ready_i). A transfer occurs when exec_valid_i && exec_ready_o.
- Non-memory payload: wb_* registers load on the accepting edge. wb_valid_o=1 next cycle (latency 1). wb_rdata_o=0.
- Memory payload: request fields are registered on accept and the FSM goes IDLE->REQ. The payload is held internally and wb_valid_o is cleared.
- FSM states IDLE, REQ, RSP:
  - REQ: dmem_req_valid_o=1; all dmem_* outputs held stable until dmem_req_ready_i.
  - Store granted -> IDLE. Writeback payload is loaded on the grant edge (wb_valid_o=1 next cycle, wb_rdata_o=0).
  - Load granted -> RSP.
  - RSP: wait for dmem_rsp_valid_i. On that edge, load wb_* with aligned data, set wb_valid_o=1, go to IDLE.
- Minimum load latency 3 cycles accept-to-wb_valid_o with zero-wait grant and next-cycle response.
- A response is never earlier than the cycle after its grant. The response is always accepted (wb register is empty in RSP), so there is no rsp-ready port.
- dmem_rsp_valid_i outside RSP: ignored. This includes stale responses after reset.
- Address and lane rules:
  - dmem_addr_o = address with the low log2(XLEN/8) bits cleared; off = those low bits.
  - Byte enables: B 1<<off; H 3<<off; W 0xF<<off; D all ones.
  - dmem_wdata_o: store data replicated across lanes of the access size.
  - Load data = (dmem_rdata_i >> 8*off), truncated to size, sign-extended unless exec_unsigned_i.
- Misaligned access (H with off[0]; W with off[1:0]≠0; D with off≠0): handled per the optional feature.
- Output stall: while wb_valid_o && !wb_ready_i, all wb_* outputs hold stable.
- Reset mid-operation drops dmem_req_valid_o immediately, combinationally from the reset.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - A misaligned memory op issues no dmem request.
  - It passes to writeback with latency 1.
  - Adds output wb_misalign_o (1 bit, reset 0), asserted with that payload.
- Undefined:
  - The misaligned offset bits are forced to the nearest lower aligned boundary for that size and the access proceeds normally.
  - wb_misalign_o does not exist.

Decomposition:
- Package mem_stage_pkg: size enum (SZ_B, SZ_H, SZ_W, SZ_D), FSM state enum, CONTROL_NOP constant, functions be_gen(size,off) and misaligned(size,off).
- Sub-module mem_load_align: combinational shift, truncate and extend of load data; parametrised by XLEN.

Test Plan:
- ALU op, wb_ready_i=1, exec_alu_i=0x1234 -> wb_valid_o next cycle, wb_alu_o=0x1234, no dmem request.
- SB to 0x1003, data 0xAB -> dmem_addr_o=0x1000, dmem_be_o=0x8, dmem_wdata_o=0xABABABAB, dmem_we_o=1; exec_ready_o=0 until grant.
- LH signed at 0x2002, rdata 0x8001_7FFF, grant delayed 2 cycles, response 3 cycles later -> wb_rdata_o=0xFFFF8001; dmem_req fields stable throughout wait.
- Load completes while wb_ready_i=0 for 4 cycles -> wb_* hold stable, exec_ready_o=0; wb_ready_i=1 -> next payload accepted same edge.
- rst_ni low in RSP, then stray dmem_rsp_valid_i after release -> wb_valid_o stays 0, state IDLE.
- LW at 0x3002 with MEM_MISALIGN_TRAP_EN -> no dmem_req_valid_o, wb_misalign_o=1 next cycle. Without the macro -> access at 0x3000, be=0xF.
